// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry instruction FIFO between fetch and decode.
// Decode sees a zero-instruction bubble carrying the last dequeued PC whenever
// the queue is empty or held. Redirects flush every entry.
module fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  input  logic                     hold,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]    pcMem    [DEPTH];
  logic [INSTR_W-1:0] instrMem [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic [PC_W-1:0]    lastPc;
  logic               enq;
  logic               deq;

  // Handshake decode and head presentation; in_ready looks at count only
  always_comb begin
    in_ready  = (count < CNT_W'(DEPTH));
    out_valid = (count != '0) && !hold;
    enq       = in_valid && in_ready && !flush;
    deq       = out_valid && out_ready;
    if (out_valid) begin
      out_pc    = pcMem[rdPtr];
      out_instr = instrMem[rdPtr];
    end else begin
      out_pc    = lastPc;
      out_instr = '0;
    end
  end

  // Entry storage; contents are left stale on flush or reset
  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      pcMem[wrPtr]    <= in_pc;
      instrMem[wrPtr] <= in_instr;
    end
  end

  // Pointers, occupancy and last dequeued PC; reset beats flush beats traffic
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      count  <= '0;
      lastPc <= '0;
    end else begin
      if (deq) begin
        lastPc <= out_pc;
      end
      if (flush) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          wrPtr <= wrPtr + PTR_W'(1);
        end
        if (deq) begin
          rdPtr <= rdPtr + PTR_W'(1);
        end
        case ({enq, deq})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        hold;
  logic        flush;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(4), .PC_W(64), .INSTR_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .hold(hold), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // 1. fill then drain
    push(64'h1000, 32'hA000_1000);
    push(64'h1004, 32'hA000_1004);
    push(64'h1008, 32'hA000_1008);
    push(64'h100C, 32'hA000_100C);
    #1;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(in_ready), 64'd0);
    chk("fill_head", out_pc, 64'h1000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_pc", out_pc, 64'h1000 + 64'(4 * i));
      chk("drain_instr", 64'(out_instr), 64'(32'hA000_1000 + 32'(4 * i)));
      chk("drain_count", 64'(count), 64'(4 - i));
      tick();
    end
    chk("drained_count", 64'(count), 64'd0);
    chk("drained_valid", 64'(out_valid), 64'd0);
    chk("drained_instr", 64'(out_instr), 64'd0);
    chk("drained_pc", out_pc, 64'h100C);

    // 2. streaming, 10 entries wraps the 2-bit pointers twice
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_pc    = 64'h4000 + 64'(4 * k);
      in_instr = 32'hB000_4000 + 32'(4 * k);
      #1;
      if (k == 0) begin
        chk("stream_first_bubble", 64'(out_valid), 64'd0);
      end else begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_pc", out_pc, 64'h4000 + 64'(4 * (k - 1)));
        chk("stream_instr", 64'(out_instr), 64'(32'hB000_4000 + 32'(4 * (k - 1))));
        chk("stream_count", 64'(count), 64'd1);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("stream_tail", out_pc, 64'h4024);
    tick();
    chk("stream_empty", 64'(count), 64'd0);
    chk("stream_last_pc", out_pc, 64'h4024);

    // 3. hold freezes the dequeue side while enqueue continues
    out_ready = 1'b0;
    push(64'h2000, 32'h00A0_0093);
    push(64'h2004, 32'h00B0_0113);
    hold = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 64'h2008; in_instr = 32'h00C0_0193;
    #1;
    chk("hold_valid", 64'(out_valid), 64'd0);
    chk("hold_instr", 64'(out_instr), 64'd0);
    chk("hold_pc", out_pc, 64'h4024);
    chk("hold_count0", 64'(count), 64'd2);
    tick();
    in_valid = 1'b0;
    chk("hold_count1", 64'(count), 64'd3);
    tick();
    chk("hold_count2", 64'(count), 64'd3);
    chk("hold_valid2", 64'(out_valid), 64'd0);
    hold = 1'b0;
    #1;
    chk("unhold_pc", out_pc, 64'h2000);
    chk("unhold_instr", 64'(out_instr), 64'h00A0_0093);
    tick();
    chk("unhold_pc2", out_pc, 64'h2004);
    tick();
    chk("unhold_pc3", out_pc, 64'h2008);
    tick();
    chk("unhold_empty", 64'(count), 64'd0);
    chk("unhold_last", out_pc, 64'h2008);

    // 4. flush while full drops the flush-cycle input and keeps last_pc
    out_ready = 1'b0;
    push(64'h5000, 32'h1);
    push(64'h5004, 32'h2);
    push(64'h5008, 32'h3);
    push(64'h500C, 32'h4);
    chk("pre_flush_count", 64'(count), 64'd4);
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'h6000; in_instr = 32'h6;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_instr", 64'(out_instr), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_last_pc", out_pc, 64'h2008);
    in_valid = 1'b1; in_pc = 64'h3000; in_instr = 32'h3000_0001;
    #1;
    chk("no_bypass", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("post_flush_valid", 64'(out_valid), 64'd1);
    chk("post_flush_pc", out_pc, 64'h3000);
    chk("post_flush_count", 64'(count), 64'd1);

    // 5. full queue refuses input even when dequeuing the same cycle
    push(64'h3004, 32'h3000_0002);
    push(64'h3008, 32'h3000_0003);
    push(64'h300C, 32'h3000_0004);
    chk("full_count", 64'(count), 64'd4);
    in_valid = 1'b1; in_pc = 64'h3010; in_instr = 32'h3000_0005; out_ready = 1'b1;
    #1;
    chk("full_ready", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b0;
    chk("full_deq_count", 64'(count), 64'd3);
    chk("full_deq_ready", 64'(in_ready), 64'd1);
    chk("full_deq_head", out_pc, 64'h3004);
    tick();
    in_valid = 1'b0;
    chk("full_accept_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_drain_pc", out_pc, 64'h3004 + 64'(4 * i));
      tick();
    end
    chk("full_drain_empty", 64'(count), 64'd0);

    // flush with a same-cycle dequeue still updates last_pc
    out_ready = 1'b0;
    push(64'h8000, 32'h8);
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_deq_count", 64'(count), 64'd0);
    chk("flush_deq_last", out_pc, 64'h8000);

    // 6. reset mid-stream
    push(64'h7000, 32'h7);
    push(64'h7004, 32'h8);
    chk("pre_reset_count", 64'(count), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_pc", out_pc, 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
